// File: rtl/crc_frame_appender_pkg.sv
// Shared types and helpers for the CRC frame appender.
package crc_frame_pkg;

    typedef enum logic {PASS = 1'b0, APPEND = 1'b1} crc_frame_state_t;

    // Number of whole bytes in a CRC of the given bit width.
    function automatic int crc_bytes(input int size);
        return size / 8;
    endfunction

endpackage

// File: rtl/crc_frame_appender_crc_calc.sv
// Generic parameterised CRC engine: one DATA_WIDTH word per valid cycle,
// synchronous hard and soft reset back to the INIT seed.
module crc_calc #(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  CRC_SIZE   = 16,
    parameter logic [CRC_SIZE-1:0] POLY       = 16'h8005,
    parameter logic [CRC_SIZE-1:0] INIT       = 16'h0000,
    parameter bit                  REF_IN     = 1'b1,
    parameter bit                  REF_OUT    = 1'b1,
    parameter logic [CRC_SIZE-1:0] XOR_OUT    = 16'hffff
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  soft_reset_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CRC_SIZE-1:0]   crc_o
);

    logic [CRC_SIZE-1:0]   r_crc;
    logic [CRC_SIZE-1:0]   w_crc_nxt;
    logic [CRC_SIZE-1:0]   w_crc_ref;
    logic [DATA_WIDTH-1:0] w_din;

    // Fold one input word into the remainder, processing its MSB first
    // (after optional bit reflection of the word).
    always_comb begin
        w_din = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            w_din[i] = REF_IN ? data_i[DATA_WIDTH-1-i] : data_i[i];
        w_crc_nxt = r_crc ^ (CRC_SIZE'(w_din) << (CRC_SIZE - DATA_WIDTH));
        for (int i = 0; i < DATA_WIDTH; i++)
            w_crc_nxt = w_crc_nxt[CRC_SIZE-1] ? ((w_crc_nxt << 1) ^ POLY) : (w_crc_nxt << 1);
    end

    // Output reflection and final XOR are applied outside the state register.
    always_comb begin
        w_crc_ref = '0;
        for (int i = 0; i < CRC_SIZE; i++)
            w_crc_ref[i] = REF_OUT ? r_crc[CRC_SIZE-1-i] : r_crc[i];
        crc_o = w_crc_ref ^ XOR_OUT;
    end

    // Remainder register; either reset returns to the seed at the next edge.
    always_ff @(posedge clk_i) begin
        if (rst_i || soft_reset_i) r_crc <= INIT;
        else if (valid_i)          r_crc <= w_crc_nxt;
    end

endmodule

// File: rtl/crc_frame_appender.sv
// Byte-stream framer: passes payload through combinationally and appends
// the frame CRC bytes after each s_last_i byte.
module crc_frame_appender
    import crc_frame_pkg::*;
#(
    parameter int                  CRC_SIZE  = 16,
    parameter logic [CRC_SIZE-1:0] POLY      = 16'h8005,
    parameter logic [CRC_SIZE-1:0] INIT      = 16'h0000,
    parameter bit                  REF_IN    = 1'b1,
    parameter bit                  REF_OUT   = 1'b1,
    parameter logic [CRC_SIZE-1:0] XOR_OUT   = 16'hffff,
    parameter bit                  LSB_FIRST = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [7:0]  s_data_i,
    input  logic        s_last_i,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [7:0]  m_data_o,
    output logic        m_last_o,
    output logic        busy_o,
    output logic [15:0] frame_cnt_o
);

    localparam int               N        = crc_bytes(CRC_SIZE);
    localparam int               IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    generate
        if ((CRC_SIZE % 8 != 0) || (CRC_SIZE < 8) || (CRC_SIZE > 64)) begin : g_bad_size
            $error("crc_frame_appender: CRC_SIZE must be a multiple of 8 in 8..64");
        end
    endgenerate

    crc_frame_state_t    r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [15:0]         r_frame_cnt;
    logic                w_crc_vld;
    logic                w_crc_soft;
    logic [CRC_SIZE-1:0] w_crc;
    logic [7:0]          w_crc_byte;

    crc_calc #(
        .DATA_WIDTH (8),
        .CRC_SIZE   (CRC_SIZE),
        .POLY       (POLY),
        .INIT       (INIT),
        .REF_IN     (REF_IN),
        .REF_OUT    (REF_OUT),
        .XOR_OUT    (XOR_OUT)
    ) u_crc (
        .clk_i        (clk_i),
        .rst_i        (~rst_n_i),
        .soft_reset_i (w_crc_soft),
        .valid_i      (w_crc_vld),
        .data_i       (s_data_i),
        .crc_o        (w_crc)
    );

    // Pick CRC byte idx in the configured transmit order.
    always_comb begin
        w_crc_byte = '0;
        for (int k = 0; k < N; k++)
            if (r_idx == IDX_W'(k))
                w_crc_byte = LSB_FIRST ? w_crc[8*k +: 8] : w_crc[CRC_SIZE-8-8*k +: 8];
    end

    // Next-state and stream outputs; everything is held idle while in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_crc_vld   = 1'b0;
        w_crc_soft  = 1'b0;
        s_ready_o   = 1'b0;
        m_valid_o   = 1'b0;
        m_data_o    = s_data_i;
        m_last_o    = 1'b0;
        if (rst_n_i) begin
            case (r_state)
                PASS: begin
                    s_ready_o = m_ready_i;
                    m_valid_o = s_valid_i;
                    w_crc_vld = s_valid_i & m_ready_i;
                    if (s_valid_i && m_ready_i && s_last_i) begin
                        w_state_nxt = APPEND;
                        w_idx_nxt   = '0;
                    end
                end
                APPEND: begin
                    m_valid_o = 1'b1;
                    m_data_o  = w_crc_byte;
                    m_last_o  = (r_idx == IDX_LAST);
                    if (m_ready_i) begin
                        if (r_idx == IDX_LAST) begin
                            w_crc_soft  = 1'b1;
                            w_state_nxt = PASS;
                            w_idx_nxt   = '0;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = PASS;
            endcase
        end
    end

    // State, byte index and completed-frame counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= PASS;
            r_idx       <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_crc_soft) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign busy_o      = (r_state == APPEND);
    assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_crc_frame_appender.sv
// Bench for crc_frame_appender: CRC-16/MAXIM (dut 0), CRC-32 LSB-first
// (dut 1) and CRC-32 MSB-first (dut 2, driven in lockstep with dut 1).
module tb_crc_frame_appender;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid [3];
    logic        s_last  [3];
    logic        m_ready [3];
    logic [7:0]  s_data  [3];
    logic        s_ready [3];
    logic        m_valid [3];
    logic        m_last  [3];
    logic        busy    [3];
    logic [7:0]  m_data  [3];
    logic [15:0] cnt     [3];

    int errors = 0;
    int checks = 0;

    int          p_size [3];
    logic [63:0] p_poly [3];
    logic [63:0] p_init [3];
    logic [63:0] p_xo   [3];
    bit          p_lsb  [3];

    logic [7:0]  pay [$];
    logic [8:0]  got [3][$];

    always #5 clk = ~clk;

    crc_frame_appender u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid[0]), .s_ready_o(s_ready[0]),
        .s_data_i(s_data[0]), .s_last_i(s_last[0]), .m_valid_o(m_valid[0]),
        .m_ready_i(m_ready[0]), .m_data_o(m_data[0]), .m_last_o(m_last[0]),
        .busy_o(busy[0]), .frame_cnt_o(cnt[0]));

    crc_frame_appender #(.CRC_SIZE(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .REF_IN(1'b1), .REF_OUT(1'b1), .XOR_OUT(32'hFFFFFFFF), .LSB_FIRST(1'b1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid[1]), .s_ready_o(s_ready[1]),
        .s_data_i(s_data[1]), .s_last_i(s_last[1]), .m_valid_o(m_valid[1]),
        .m_ready_i(m_ready[1]), .m_data_o(m_data[1]), .m_last_o(m_last[1]),
        .busy_o(busy[1]), .frame_cnt_o(cnt[1]));

    crc_frame_appender #(.CRC_SIZE(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .REF_IN(1'b1), .REF_OUT(1'b1), .XOR_OUT(32'hFFFFFFFF), .LSB_FIRST(1'b0)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid[2]), .s_ready_o(s_ready[2]),
        .s_data_i(s_data[2]), .s_last_i(s_last[2]), .m_valid_o(m_valid[2]),
        .m_ready_i(m_ready[2]), .m_data_o(m_data[2]), .m_last_o(m_last[2]),
        .busy_o(busy[2]), .frame_cnt_o(cnt[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reflected (right-shifting) CRC over the current payload.
    function automatic logic [63:0] ref_crc(input int d);
        logic [63:0] c, rp, rinit, mask;
        c = '0; rp = '0; rinit = '0;
        mask = (p_size[d] == 64) ? '1 : ((64'd1 << p_size[d]) - 64'd1);
        for (int i = 0; i < p_size[d]; i++) begin
            rp[p_size[d]-1-i]    = p_poly[d][i];
            rinit[p_size[d]-1-i] = p_init[d][i];
        end
        c = rinit;
        foreach (pay[k]) begin
            c = c ^ {56'd0, pay[k]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ rp) : (c >> 1);
        end
        return (c ^ p_xo[d]) & mask;
    endfunction

    function automatic logic [7:0] crc_byte(input int d, input logic [63:0] c, input int j);
        logic [63:0] s;
        s = p_lsb[d] ? (c >> (8*j)) : (c >> (p_size[d] - 8 - 8*j));
        return s[7:0];
    endfunction

    task automatic drive(input int d, input logic sv, input logic [7:0] sd, input logic sl, input logic mr);
        s_valid[d] = sv; s_data[d] = sd; s_last[d] = sl; m_ready[d] = mr;
        if (d == 1) begin
            s_valid[2] = sv; s_data[2] = sd; s_last[2] = sl; m_ready[2] = mr;
        end
    endtask

    // Push the payload through dut d (and its twin for d==1), logging every
    // downstream handshake; stop_crc>0 ends after that many CRC bytes.
    task automatic run(input int d, input bit rnd, input int stop_crc, input string tag);
        int p, cyc, ncrc, L, n;
        bit done, stall, last_hs;
        logic [7:0] pd;
        logic pl, sv, mr;
        p = 0; cyc = 0; ncrc = 0; done = 0; stall = 0; last_hs = 0; pd = '0; pl = 0;
        L = pay.size(); n = p_size[d] / 8;
        while (!done) begin
            if (cyc >= 500) begin
                chk({tag, "_timeout"}, 64'(cyc), 64'd0);
                break;
            end
            sv = (p < L);
            mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(d, sv, sv ? pay[p] : 8'($urandom), sv ? (p == L - 1) : 1'($urandom_range(0, 1)), mr);
            @(negedge clk);
            if (last_hs) chk({tag, "_busy_rise"}, 64'(busy[d]), 64'd1);
            if (busy[d]) begin
                chk({tag, "_sready_append"}, 64'(s_ready[d]), 64'd0);
                chk({tag, "_mvalid_append"}, 64'(m_valid[d]), 64'd1);
                if (stall) begin
                    chk({tag, "_hold_data"}, 64'(m_data[d]), 64'(pd));
                    chk({tag, "_hold_last"}, 64'(m_last[d]), 64'(pl));
                end
            end
            last_hs = sv && s_ready[d] && (p == L - 1);
            if (m_valid[d] && m_ready[d]) begin
                got[d].push_back({m_last[d], m_data[d]});
                if (busy[d]) ncrc++;
                if (m_last[d]) done = 1;
                if (stop_crc != 0 && ncrc == stop_crc) done = 1;
            end
            if (d == 1 && m_valid[2] && m_ready[2]) got[2].push_back({m_last[2], m_data[2]});
            stall = busy[d] && !m_ready[d];
            pd = m_data[d]; pl = m_last[d];
            if (sv && s_ready[d]) p++;
            @(posedge clk); #1;
            cyc++;
        end
        drive(d, 1'b0, 8'h00, 1'b0, 1'b1);
        if (!rnd && stop_crc == 0) chk({tag, "_cycles"}, 64'(cyc), 64'(L + n));
        if (stop_crc == 0) chk({tag, "_busy_fall"}, 64'(busy[d]), 64'd0);
    endtask

    // Compare the logged output of dut d with payload + model CRC, then clear it.
    task automatic check_frame(input int d, input string tag);
        int L, n;
        logic [63:0] c;
        logic [8:0] exp;
        L = pay.size(); n = p_size[d] / 8; c = ref_crc(d);
        chk({tag, "_len"}, 64'(got[d].size()), 64'(L + n));
        for (int i = 0; i < L + n; i++) begin
            exp = (i < L) ? {1'b0, pay[i]} : {(i == L + n - 1), crc_byte(d, c, i - L)};
            if (i < got[d].size()) chk($sformatf("%s_b%0d", tag, i), 64'(got[d][i]), 64'(exp));
        end
    endtask

    task automatic set_check_string();
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    endtask

    initial begin
        p_size = '{16, 32, 32};
        p_poly = '{64'h8005, 64'h04C11DB7, 64'h04C11DB7};
        p_init = '{64'h0, 64'hFFFFFFFF, 64'hFFFFFFFF};
        p_xo   = '{64'hFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF};
        p_lsb  = '{1'b1, 1'b1, 1'b0};
        for (int d = 0; d < 3; d++) begin
            s_valid[d] = 0; s_last[d] = 0; m_ready[d] = 0; s_data[d] = 0;
        end
        rst_n = 1'b0;

        // Reset: outputs idle even with traffic presented.
        drive(0, 1'b1, 8'hA5, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sready", 64'(s_ready[0]), 64'd0);
        chk("rst_mvalid", 64'(m_valid[0]), 64'd0);
        chk("rst_mlast",  64'(m_last[0]),  64'd0);
        chk("rst_busy",   64'(busy[0]),    64'd0);
        chk("rst_cnt",    64'(cnt[0]),     64'd0);
        drive(0, 1'b0, 8'h00, 1'b0, 1'b1);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // CRC-16/MAXIM check string.
        set_check_string();
        run(0, 0, 0, "maxim");
        chk("maxim_crc0", 64'(got[0][9]),  64'h0C2);
        chk("maxim_crc1", 64'(got[0][10]), 64'h144);
        check_frame(0, "maxim");
        got[0].delete();
        chk("maxim_cnt", 64'(cnt[0]), 64'd1);

        // Single zero byte then the check string, back to back.
        pay.delete(); pay.push_back(8'h00);
        run(0, 0, 0, "zero");
        chk("zero_crc0", 64'(got[0][1]), 64'h0FF);
        chk("zero_crc1", 64'(got[0][2]), 64'h1FF);
        check_frame(0, "zero");
        got[0].delete();
        set_check_string();
        run(0, 0, 0, "b2b");
        chk("b2b_crc0", 64'(got[0][9]),  64'h0C2);
        chk("b2b_crc1", 64'(got[0][10]), 64'h144);
        check_frame(0, "b2b");
        got[0].delete();
        chk("b2b_cnt", 64'(cnt[0]), 64'd3);

        // Random back-pressure on the check string.
        run(0, 1, 0, "bp");
        chk("bp_crc0", 64'(got[0][9]),  64'h0C2);
        chk("bp_crc1", 64'(got[0][10]), 64'h144);
        check_frame(0, "bp");
        got[0].delete();
        chk("bp_cnt", 64'(cnt[0]), 64'd4);

        // CRC-32, both byte orders.
        run(1, 0, 0, "crc32");
        chk("crc32l_b9",  64'(got[1][9]),  64'h026);
        chk("crc32l_b12", 64'(got[1][12]), 64'h1CB);
        chk("crc32m_b9",  64'(got[2][9]),  64'h0CB);
        chk("crc32m_b12", 64'(got[2][12]), 64'h126);
        check_frame(1, "crc32l");
        check_frame(2, "crc32m");
        got[1].delete(); got[2].delete();

        // Random payloads with random back-pressure on the CRC-32 pair.
        for (int f = 0; f < 4; f++) begin
            int len;
            len = $urandom_range(1, 20);
            pay.delete();
            for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
            run(1, 1, 0, $sformatf("rnd%0d", f));
            check_frame(1, $sformatf("rnd%0dl", f));
            check_frame(2, $sformatf("rnd%0dm", f));
            got[1].delete(); got[2].delete();
        end
        chk("crc32_cnt", 64'(cnt[1]), 64'd5);

        // Reset after the first CRC byte abandons the frame.
        set_check_string();
        run(0, 0, 1, "abort");
        chk("abort_len",  64'(got[0].size()), 64'd10);
        chk("abort_crc0", 64'(got[0][9]), 64'h0C2);
        got[0].delete();
        rst_n = 1'b0;
        drive(0, 1'b1, 8'h55, 1'b0, 1'b1);
        #1;
        chk("abort_rst_mvalid", 64'(m_valid[0]), 64'd0);
        chk("abort_rst_sready", 64'(s_ready[0]), 64'd0);
        chk("abort_rst_busy",   64'(busy[0]),    64'd0);
        chk("abort_rst_cnt",    64'(cnt[0]),     64'd0);
        repeat (2) @(posedge clk);
        drive(0, 1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_post_mvalid", 64'(m_valid[0]), 64'd0);
        chk("abort_post_busy",   64'(busy[0]),    64'd0);
        run(0, 0, 0, "recover");
        chk("recover_crc0", 64'(got[0][9]),  64'h0C2);
        chk("recover_crc1", 64'(got[0][10]), 64'h144);
        check_frame(0, "recover");
        got[0].delete();
        chk("recover_cnt", 64'(cnt[0]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc_frame_appender.md
# crc_frame_appender

Byte-stream framer that sequences a `crc_calc` instance (DATA_WIDTH = 8) over each frame's payload and then appends the CRC bytes before the next frame. It sits on the transmit path between the packet source and the serializer/optical link. Payload passes through with zero latency. The block owns the CRC engine's `valid_i` and `soft_reset_i`, so no other logic drives the engine.

## Interface
Parameters:
- `POLY`, default 16'h8005: CRC polynomial, forwarded to `crc_calc`.
- `CRC_SIZE`, default 16: CRC width. Multiple of 8, range 8..64.
- `INIT`, default 16'h0000: CRC seed, forwarded.
- `REF_IN`, default 1: input reflection, forwarded.
- `REF_OUT`, default 1: output reflection, forwarded.
- `XOR_OUT`, default 16'hffff: final XOR, forwarded.
- `LSB_FIRST`, default 1: 1 sends CRC byte [7:0] first; 0 sends the most significant byte first.

Ports:
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `s_valid_i`  in  1  upstream byte valid.
- `s_ready_o`  out  1  upstream ready.
- `s_data_i`  in  8  payload byte.
- `s_last_i`  in  1  last payload byte of the frame.
- `m_valid_o`  out  1  downstream valid.
- `m_ready_i`  in  1  downstream ready.
- `m_data_o`  out  8  payload or CRC byte.
- `m_last_o`  out  1  last byte of the frame, i.e. the final CRC byte.
- `busy_o`  out  1  high while in APPEND.
- `frame_cnt_o`  out  16  count of completed frames; wraps.

## Operation
Definitions:
- `N = CRC_SIZE/8`.
- Handshake: `valid & ready` at a rising edge.

State machine with two states, PASS and APPEND. Reset state is PASS.

PASS:
- Combinational passthrough: `m_valid_o = s_valid_i`, `m_data_o = s_data_i`, `s_ready_o = m_ready_i`, `m_last_o = 0`.
- `crc_calc.valid_i = s_valid_i & m_ready_i`, with `data_i = s_data_i`.
- On a handshake with `s_last_i = 1`: go to APPEND and set `idx <= 0`.

APPEND:
- `s_ready_o = 0`, `m_valid_o = 1`, `crc_calc.valid_i = 0`. The CRC value is therefore frozen.
- `m_data_o` = CRC byte `idx` of `crc_o`:
  - `LSB_FIRST = 1`: `crc_o[8*idx +: 8]`.
  - `LSB_FIRST = 0`: `crc_o[CRC_SIZE-8-8*idx +: 8]`.
- `m_last_o = (idx == N-1)`.
- On a downstream handshake with `idx < N-1`: `idx++`.
- On a downstream handshake with `idx == N-1`:
  - assert `crc_calc.soft_reset_i` for that cycle, so the CRC is INIT at the next edge;
  - `frame_cnt_o++`, wrapping 16'hFFFF to 0;
  - go to PASS.

`idx` is `$clog2(N)` bits wide, minimum 1. `s_last_i` is ignored outside a PASS handshake.

Reset:
- While `rst_n_i` is low: `s_ready_o = 0`, `m_valid_o = 0`, `m_last_o = 0`, `busy_o = 0`, `frame_cnt_o = 0`, state PASS, `idx = 0`.
- `crc_calc.rst_i = ~rst_n_i`. The engine holds INIT from the first edge under reset.

Reset asserted mid-APPEND: the partial frame is abandoned and no further CRC bytes are output. After release the block is in PASS with the CRC at INIT. Recovery of the downstream frame boundary is the sink's responsibility.

## Timing
- Payload latency is 0 cycles (combinational).
- The first CRC byte is valid in the cycle after the `s_last_i` handshake.
- With `m_ready_i = 1`, a frame of L bytes occupies exactly L+N cycles on the output.
- The next frame's first byte can be accepted in the cycle after the final CRC handshake. There are no idle cycles between frames.
- Back-pressure in APPEND: `m_data_o`, `m_last_o` and `idx` stay stable until the handshake.
- `busy_o` is registered state. It rises the cycle after the `s_last_i` handshake and falls the cycle after the final CRC handshake.

## Structure
- Package `crc_frame_pkg` holds:
  - `typedef enum logic {PASS, APPEND} crc_frame_state_t`;
  - function `crc_bytes(int size)` returning `size/8`.
- One sub-module: `crc_calc`, instantiated with DATA_WIDTH = 8 and the forwarded parameters.
- Elaboration assertion: `CRC_SIZE % 8 == 0`.

## Test plan
- Default parameters (CRC-16/MAXIM), payload "123456789" (0x31..0x39), `m_ready_i = 1`: output is the 9 payload bytes, then 0xC2, then 0x44 with `m_last_o = 1`; `frame_cnt_o = 1`.
- CRC-32 parameters (POLY 04C11DB7, INIT/XOR_OUT FFFFFFFF, reflected), same payload: appended bytes are 0x26, 0x39, 0xF4, 0xCB. With `LSB_FIRST = 0` the order is 0xCB, 0xF4, 0x39, 0x26.
- Single-byte frame 0x00 (default parameters), immediately followed by "123456789": first frame appends 0xFF, 0xFF; second frame appends 0xC2, 0x44, with no gap cycle. This proves the soft reset.
- Random `m_ready_i` toggling (50%) during payload and APPEND: the byte sequence is identical to the first scenario; `m_data_o` holds while `m_ready_i = 0`; `s_ready_o = 0` throughout APPEND.
- Assert `rst_n_i` after the first CRC byte is sent, then release and send "123456789": no second CRC byte appears; the new frame yields 0xC2, 0x44; `frame_cnt_o` restarts from 0 and reads 1.
